// File: rtl/zion_basic_circuit_lib_rr_hold_arb.sv
// Purpose: N-way arbiter feeding a single-entry holding register (round-robin, or fixed priority
//          when ZION_RR_HOLD_ARB_FIXED_PRI_EN is defined).
// Latency: one cycle from grant (oGnt, combinational) to oVld; one item per cycle sustained.
// Backpressure: with oVld=1 and iRdy=0 no grant is issued and the held item and pointer are frozen.
module zion_basic_circuit_lib_rr_hold_arb #(
  parameter int                NUM_REQ  = 4,
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INI_DATA = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             iReq,
  input  logic [NUM_REQ*WIDTH-1:0]       iDat,
  output logic [NUM_REQ-1:0]             oGnt,
  input  logic                           iClr,
  output logic                           oVld,
  input  logic                           iRdy,
  output logic [WIDTH-1:0]               oDat,
  output logic [$clog2(NUM_REQ)-1:0]     oSrc
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   win_idx;
  logic               win_found;
  logic               load_opp;
  logic               grant;
  logic [SRC_W-1:0]   search_base;

`ifdef ZION_RR_HOLD_ARB_FIXED_PRI_EN
  // Fixed priority: the search always starts at requester 0, no pointer is kept.
  assign search_base = '0;
`else
  logic [SRC_W-1:0]   ptr_q, ptr_d;

  assign search_base = ptr_q;

  // Next pointer: one past the winner on a grant, wrapping at NUM_REQ; otherwise held.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      if (win_idx == SRC_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + SRC_W'(1);
      end
    end
  end

  // Pointer register; cleared only by reset, kept across iClr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Circular search for the first active requester at or after search_base.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(search_base) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && iReq[idx]) begin
        win_found = 1'b1;
        win_idx   = idx[SRC_W-1:0];
      end
    end
  end

  // The register can take a new item when empty or being drained; clear and reset block loading.
  assign load_opp = ((state_q == ST_EMPTY) || iRdy) && !iClr && rst;
  assign grant    = load_opp && win_found;

  // One-hot grant, only on a requesting bit and only with a load opportunity.
  always_comb begin
    oGnt = '0;
    if (grant) begin
      oGnt = NUM_REQ'(1) << win_idx;
    end
  end

  // Next-state and holding-register contents.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    src_d   = src_q;
    if (iClr) begin
      state_d = ST_EMPTY;
      dat_d   = INI_DATA;
      src_d   = '0;
    end else if (grant) begin
      state_d = ST_FULL;
      dat_d   = iDat[int'(win_idx)*WIDTH +: WIDTH];
      src_d   = win_idx;
    end else if ((state_q == ST_FULL) && iRdy) begin
      // Drained with nothing to reload: contents are left as they were.
      state_d = ST_EMPTY;
    end
  end

  // State and holding register; reset discards any held item.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      dat_q   <= INI_DATA;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      src_q   <= src_d;
    end
  end

  assign oVld = (state_q == ST_FULL);
  assign oDat = dat_q;
  assign oSrc = src_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_rr_hold_arb.sv
// Bench for the round-robin hold arbiter: directed scenarios plus randomized traffic,
// compared against a simple per-cycle reference model of grant and holding-register rules.
// The reference model follows ZION_RR_HOLD_ARB_FIXED_PRI_EN when it is defined.
module tb_zion_basic_circuit_lib_rr_hold_arb;

  localparam int          N   = 4;
  localparam int          W   = 8;
  localparam logic [7:0]  INI = 8'h3C;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     iReq;
  logic [N*W-1:0]   iDat;
  logic [N-1:0]     oGnt;
  logic             iClr;
  logic             oVld;
  logic             iRdy;
  logic [W-1:0]     oDat;
  logic [1:0]       oSrc;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_full;
  logic [7:0] m_dat;
  int         m_src;
  int         m_ptr;

  zion_basic_circuit_lib_rr_hold_arb #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .INI_DATA(INI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .iReq(iReq),
    .iDat(iDat),
    .oGnt(oGnt),
    .iClr(iClr),
    .oVld(oVld),
    .iRdy(iRdy),
    .oDat(oDat),
    .oSrc(oSrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner under the current inputs, or -1 when nothing may be granted.
  function automatic int model_win();
    int start;
    if (rst !== 1'b1) return -1;
    if (iClr) return -1;
    if (m_full && !iRdy) return -1;
`ifdef ZION_RR_HOLD_ARB_FIXED_PRI_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (iReq[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check grant, clock, update model, check outputs.
  task automatic cyc(input logic r, input logic c, input logic rdy, input logic [N-1:0] req,
                     input logic [N*W-1:0] dat, output logic [N-1:0] g_seen);
    int          w;
    logic [31:0] exp_g;
    @(negedge clk);
    rst  = r;
    iClr = c;
    iRdy = rdy;
    iReq = req;
    iDat = dat;
    #1;
    w     = model_win();
    exp_g = (w < 0) ? 32'd0 : (32'd1 << w);
    chk("gnt", {28'd0, oGnt}, exp_g);
    g_seen = oGnt;
    @(posedge clk);
    if (!r) begin
      m_full = 0; m_dat = INI; m_src = 0; m_ptr = 0;
    end else if (c) begin
      m_full = 0; m_dat = INI; m_src = 0;
    end else if (w >= 0) begin
      m_full = 1; m_dat = dat[w*W +: W]; m_src = w; m_ptr = (w + 1) % N;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    #1;
    chk("vld", {31'd0, oVld}, {31'd0, m_full});
    chk("dat", {24'd0, oDat}, {24'd0, m_dat});
    chk("src", {30'd0, oSrc}, m_src);
  endtask

  initial begin
    logic [N-1:0]   g;
    logic [N*W-1:0] d;
    logic [N-1:0]   exp_seq [5];
    m_full = 0; m_dat = INI; m_src = 0; m_ptr = 0;
    rst = 0; iClr = 0; iRdy = 0; iReq = '0; iDat = '0;

    // Reset, then check reset state explicitly
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, '0, g);
    cyc(1'b0, 1'b0, 1'b1, 4'b1111, '0, g);
    chk("rst_gnt", {28'd0, g}, 32'd0);
    chk("rst_vld", {31'd0, oVld}, 32'd0);
    chk("rst_dat", {24'd0, oDat}, {24'd0, INI});
    chk("rst_src", {30'd0, oSrc}, 32'd0);

    // All requesting, downstream always ready
`ifdef ZION_RR_HOLD_ARB_FIXED_PRI_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 8; i++) begin
      d = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
      cyc(1'b1, 1'b0, 1'b1, 4'b1111, d, g);
      if (i < 5) chk("s33_gnt", {28'd0, g}, {28'd0, exp_seq[i]});
      chk("s33_vld", {31'd0, oVld}, 32'd1);
    end

    // Empty first, then a single request followed by a stall
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, '0, g);
    d = 32'h00A5_0000;
    cyc(1'b1, 1'b0, 1'b0, 4'b0100, d, g);
    chk("s34_gnt", {28'd0, g}, 32'b0100);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'b0100, d, g);
      chk("s34_stall_gnt", {28'd0, g}, 32'd0);
      chk("s34_dat", {24'd0, oDat}, 32'hA5);
      chk("s34_src", {30'd0, oSrc}, 32'd2);
    end

    // Clear wins over ready and request
    cyc(1'b1, 1'b1, 1'b1, 4'b0001, 32'h0000_0077, g);
    chk("s35_gnt", {28'd0, g}, 32'd0);
    chk("s35_vld", {31'd0, oVld}, 32'd0);
    chk("s35_dat", {24'd0, oDat}, {24'd0, INI});
    cyc(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_0077, g);
    chk("s35_regnt", {28'd0, g}, 32'b0001);

    // Reset while full discards the item and restarts the pointer
    cyc(1'b0, 1'b0, 1'b1, 4'b1111, 32'h1122_3344, g);
    chk("s36_gnt", {28'd0, g}, 32'd0);
    chk("s36_vld", {31'd0, oVld}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 4'b1111, 32'h1122_3344, g);
    chk("s36_first", {28'd0, g}, 32'b0001);

    // Grant to the last requester, then pointer wrap
    cyc(1'b1, 1'b0, 1'b1, 4'b1000, 32'h9900_0000, g);
    chk("s38_g3", {28'd0, g}, 32'b1000);
    cyc(1'b1, 1'b0, 1'b1, 4'b1001, 32'h9900_0011, g);
    chk("s38_wrap", {28'd0, g}, 32'b0001);

    // Two alternating requesters held
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'b1010, 32'hDD00_BB00, g);
`ifdef ZION_RR_HOLD_ARB_FIXED_PRI_EN
      chk("s37_gnt", {28'd0, g}, 32'b0010);
`endif
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 9) < 7), N'($urandom), $urandom, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
